lsm303_poll_sequencer: RTL and testbench

Command sequencer and arbiter that owns the I2C transaction engine driving the LSM303 accelerometer/magnetometer. After reset it issues the two sensor-enable writes. It then runs a periodic four-read poll round and latches the results into sample registers. PC-issued transactions from the FrontPanel wire-ins are interleaved between poll reads. The block sits between the okWireIn/okWireOut endpoints and the I2C interface FSM, replacing the direct PC-to-FSM start wiring.

---
 rtl/lsm303_poll_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_lsm303_poll_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsm303_poll_sequencer.sv
// LSM303 poll sequencer: issues the two sensor-enable writes after reset,
// then runs a periodic four-read poll round into sample registers while
// interleaving PC transactions, all through one I2C transaction engine.
module lsm303_poll_sequencer #(
    parameter int POLL_DIV = 100000,
    parameter int TIMEOUT  = 65535
) (
    input  logic        FSM_Clk,
    input  logic        Reset,
    input  logic        PcReq,
    input  logic [31:0] PcCmd,
    output logic [31:0] PcReadData,
    output logic        PcAck,
    output logic        I2cGo,
    output logic [31:0] I2cCmd,
    input  logic        I2cDone,
    input  logic [31:0] I2cReadData,
    output logic [31:0] AccelXY,
    output logic [15:0] AccelZ,
    output logic [31:0] MagXZ,
    output logic [15:0] MagY,
    output logic        SampleValid,
    output logic        Busy,
    output logic        Error
);
    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int OW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {INIT, IDLE, BUSY, GAP} stateT;

    stateT         state, nextState;
    logic [1:0]    initIdx;      // next init slot; 2 once both enables are done
    logic [2:0]    pollSlot;     // next slot of the current poll round
    logic [2:0]    curSlot;      // slot of the transaction in flight
    logic          curIsPc;      // in-flight transaction belongs to the PC
    logic [OW-1:0] toCnt;
    logic [TW-1:0] pollTimer;
    logic          pcPending, pollPending, pcReqD;
    logic [31:0]   pcCmdLat;
    logic [31:0]   shAccelXY, shMagXZ;
    logic [15:0]   shAccelZ, shMagY;

    logic          grant, grantPc, txEnd, timedOut;
    logic [2:0]    grantSlot;
    logic          initDone, wrap, pcRise, pollDone;

    // Fixed slot table, packed {0, slave, sub, rw(1=write), wdata, bytes}
    function automatic logic [31:0] slotCmd(input logic [2:0] idx);
        case (idx)
            3'd0:    slotCmd = {1'b0, 7'h19, 7'h20, 1'b1, 8'h57, 8'h00};
            3'd1:    slotCmd = {1'b0, 7'h1E, 7'h02, 1'b1, 8'h00, 8'h00};
            3'd2:    slotCmd = {1'b0, 7'h19, 7'h28, 1'b0, 8'h00, 8'h04};
            3'd3:    slotCmd = {1'b0, 7'h19, 7'h2C, 1'b0, 8'h00, 8'h02};
            3'd4:    slotCmd = {1'b0, 7'h1E, 7'h03, 1'b0, 8'h00, 8'h04};
            3'd5:    slotCmd = {1'b0, 7'h1E, 7'h07, 1'b0, 8'h00, 8'h02};
            default: slotCmd = '0;
        endcase
    endfunction

    assign initDone = (initIdx == 2'd2);
    assign wrap     = initDone && (pollTimer == TW'(POLL_DIV - 1));
    assign pcRise   = PcReq && !pcReqD;
    assign pollDone = txEnd && !curIsPc && (curSlot == 3'd5);
    assign Busy     = (state != IDLE);

    // State register
    always_ff @(posedge FSM_Clk or posedge Reset) begin
        if (Reset) state <= INIT;
        else       state <= nextState;
    end

    // Next state, arbitration and completion detection
    always_comb begin
        nextState = state;
        grant     = 1'b0;
        grantPc   = 1'b0;
        grantSlot = 3'd0;
        txEnd     = 1'b0;
        timedOut  = 1'b0;
        case (state)
            INIT: begin
                nextState = BUSY;
                grant     = 1'b1;
                grantSlot = {1'b0, initIdx};
            end
            IDLE: begin
                // PC wins; priority is re-evaluated before every slot
                if (pcPending) begin
                    nextState = BUSY;
                    grant     = 1'b1;
                    grantPc   = 1'b1;
                end else if (pollPending) begin
                    nextState = BUSY;
                    grant     = 1'b1;
                    grantSlot = pollSlot;
                end
            end
            BUSY: begin
                // a real completion in the limit cycle still counts as success
                timedOut = !I2cDone && (toCnt == OW'(TIMEOUT));
                if (I2cDone || timedOut) begin
                    nextState = GAP;
                    txEnd     = 1'b1;
                end
            end
            GAP:     nextState = initDone ? IDLE : INIT;
            default: nextState = INIT;
        endcase
    end

    // Transaction launch/teardown, timeout counter and PC result capture
    always_ff @(posedge FSM_Clk or posedge Reset) begin
        if (Reset) begin
            I2cGo      <= 1'b0;
            I2cCmd     <= '0;
            curSlot    <= '0;
            curIsPc    <= 1'b0;
            toCnt      <= '0;
            initIdx    <= '0;
            PcAck      <= 1'b0;
            PcReadData <= '0;
        end else begin
            PcAck <= 1'b0;
            if (grant) begin
                I2cGo   <= 1'b1;
                I2cCmd  <= grantPc ? pcCmdLat : slotCmd(grantSlot);
                curSlot <= grantSlot;
                curIsPc <= grantPc;
                toCnt   <= '0;
            end else if (txEnd) begin
                I2cGo <= 1'b0;
                if (curIsPc) begin
                    PcAck <= 1'b1;
                    if (!timedOut) PcReadData <= I2cReadData;
                end else if (curSlot < 3'd2) begin
                    initIdx <= initIdx + 2'd1;
                end
            end else if (state == BUSY) begin
                toCnt <= toCnt + 1'b1;
            end
        end
    end

    // PC request edge detect, poll timer, pending flags and sticky error
    always_ff @(posedge FSM_Clk or posedge Reset) begin
        if (Reset) begin
            pcReqD      <= 1'b0;
            pcPending   <= 1'b0;
            pcCmdLat    <= '0;
            pollPending <= 1'b0;
            pollSlot    <= 3'd2;
            pollTimer   <= '0;
            Error       <= 1'b0;
        end else begin
            pcReqD <= PcReq;
            // pcPending stays set while the PC transaction is in flight,
            // so edges during that window are dropped too
            if (txEnd && curIsPc)
                pcPending <= 1'b0;
            else if (pcRise && !pcPending) begin
                pcPending <= 1'b1;
                pcCmdLat  <= PcCmd;
            end

            if (initDone) pollTimer <= wrap ? '0 : pollTimer + 1'b1;

            // a wrap landing on the cycle slot 5 finishes is not an overrun
            if (wrap && (!pollPending || pollDone)) begin
                pollPending <= 1'b1;
                pollSlot    <= 3'd2;
            end else if (pollDone) begin
                pollPending <= 1'b0;
            end else if (txEnd && !curIsPc && curSlot >= 3'd2) begin
                pollSlot <= pollSlot + 3'd1;
            end

            Error <= Error | timedOut | (wrap && pollPending && !pollDone);
        end
    end

    // Shadow capture per read slot; slot 5 commits the whole sample set
    always_ff @(posedge FSM_Clk or posedge Reset) begin
        if (Reset) begin
            shAccelXY   <= '0;
            shAccelZ    <= '0;
            shMagXZ     <= '0;
            shMagY      <= '0;
            AccelXY     <= '0;
            AccelZ      <= '0;
            MagXZ       <= '0;
            MagY        <= '0;
            SampleValid <= 1'b0;
        end else begin
            SampleValid <= 1'b0;
            if (txEnd && !curIsPc && !timedOut) begin
                case (curSlot)
                    3'd2:    shAccelXY <= I2cReadData;
                    3'd3:    shAccelZ  <= I2cReadData[15:0];
                    3'd4:    shMagXZ   <= I2cReadData;
                    3'd5:    shMagY    <= I2cReadData[15:0];
                    default: ;
                endcase
            end
            if (pollDone) begin
                AccelXY     <= shAccelXY;
                AccelZ      <= shAccelZ;
                MagXZ       <= shMagXZ;
                MagY        <= timedOut ? shMagY : I2cReadData[15:0];
                SampleValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsm303_poll_sequencer.sv
// Bench for lsm303_poll_sequencer: the bench plays the I2C engine and the PC,
// and predicts command order and sample values from the slot rules.
module tb_lsm303_poll_sequencer;
    localparam int POLL_DIV = 200;
    localparam int TIMEOUT  = 100;

    logic        FSM_Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        PcReq = 1'b0;
    logic [31:0] PcCmd = '0;
    logic        I2cDone = 1'b0;
    logic [31:0] I2cReadData = '0;
    logic [31:0] PcReadData, I2cCmd, AccelXY, MagXZ;
    logic [15:0] AccelZ, MagY;
    logic        PcAck, I2cGo, SampleValid, Busy, Error;

    int          vecs = 0;
    int          miscompares = 0;
    logic [31:0] slotTab [0:5];
    logic [31:0] sh [2:5];      // model of what each read slot last returned
    logic [31:0] expPcRd;
    logic [31:0] pcExpCmd;

    lsm303_poll_sequencer #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .FSM_Clk(FSM_Clk), .Reset(Reset), .PcReq(PcReq), .PcCmd(PcCmd),
        .PcReadData(PcReadData), .PcAck(PcAck), .I2cGo(I2cGo), .I2cCmd(I2cCmd),
        .I2cDone(I2cDone), .I2cReadData(I2cReadData), .AccelXY(AccelXY),
        .AccelZ(AccelZ), .MagXZ(MagXZ), .MagY(MagY), .SampleValid(SampleValid),
        .Busy(Busy), .Error(Error)
    );

    always #5 FSM_Clk = ~FSM_Clk;

    function automatic logic [31:0] pack(input logic [6:0] slave, input logic [6:0] sub,
                                         input logic isWrite, input logic [7:0] wdata,
                                         input logic [7:0] nBytes);
        return {1'b0, slave, sub, isWrite, wdata, nBytes};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for I2cGo, then check grant latency and command
    task automatic waitGo(input logic [31:0] cmdExp, input int expWait, output bit ok);
        int w;
        w = 0;
        do begin
            @(negedge FSM_Clk);
            w++;
        end while (I2cGo !== 1'b1 && w < 3000);
        check("go_asserted", I2cGo, 1);
        ok = (I2cGo === 1'b1);
        if (ok && expWait > 0) check("grant_latency", w, expWait);
        if (ok) check("i2c_cmd", I2cCmd, cmdExp);
    endtask

    // Serve one transaction; slot -1 is the PC. pcMode 1 raises a PC request
    // (plus an extra edge while pending), pcMode 2 re-edges PcReq in flight.
    task automatic serveTx(input int slot, input int lat, input logic [31:0] data,
                           input bit doDone, input int expWait, input int pcMode);
        bit ok, svSeen, dropped;
        int hi;
        logic [31:0] r, cmdExp;
        if (slot < 0) cmdExp = pcExpCmd;
        else          cmdExp = slotTab[slot];
        waitGo(cmdExp, expWait, ok);
        if (!ok) return;
        svSeen  = 1'b0;
        dropped = 1'b0;
        if (doDone) begin
            for (int k = 0; k < lat; k++) begin
                @(negedge FSM_Clk);
                if (SampleValid !== 1'b0) svSeen = 1'b1;
                if (I2cGo !== 1'b1) dropped = 1'b1;
                if (pcMode == 1 && k == 2) begin
                    r = $urandom; r[31] = 1'b0;
                    PcCmd = r; pcExpCmd = r; PcReq = 1'b1;
                end
                if (pcMode == 1 && k == 4) PcReq = 1'b0;
                if (pcMode == 1 && k == 6) begin PcCmd = ~pcExpCmd; PcReq = 1'b1; end
                if (pcMode == 2 && k == 1) PcReq = 1'b0;
                if (pcMode == 2 && k == 3) begin PcCmd = $urandom; PcReq = 1'b1; end
            end
            check("go_held", dropped, 0);
            check("no_early_sample", svSeen, 0);
            I2cReadData = data;
            I2cDone     = 1'b1;
            @(negedge FSM_Clk);
            I2cDone     = 1'b0;
            I2cReadData = $urandom;
        end else begin
            hi = 1;
            while (I2cGo === 1'b1 && hi < 1000) begin
                @(negedge FSM_Clk);
                if (I2cGo === 1'b1) hi++;
            end
            check("timeout_len", hi, TIMEOUT + 1);
        end
        check("go_dropped", I2cGo, 0);
        if (slot < 0) begin
            if (doDone) expPcRd = data;
            check("pc_ack", PcAck, 1);
            check("pc_rdata", PcReadData, expPcRd);
        end else begin
            check("pc_ack_quiet", PcAck, 0);
        end
        if (slot >= 2 && doDone) sh[slot] = (slot == 3 || slot == 5) ? {16'h0, data[15:0]} : data;
        if (slot == 5) begin
            check("sample_valid", SampleValid, 1);
            check("accel_xy", AccelXY, sh[2]);
            check("accel_z", AccelZ, sh[3]);
            check("mag_xz", MagXZ, sh[4]);
            check("mag_y", MagY, sh[5]);
        end else begin
            check("sample_quiet", SampleValid, 0);
        end
    endtask

    task automatic randRound();
        for (int s = 2; s <= 5; s++)
            serveTx(s, $urandom_range(5, 15), $urandom, 1'b1, (s == 2) ? 0 : 2, 0);
    endtask

    initial begin
        bit ok;
        int goCnt;
        slotTab[0] = pack(7'h19, 7'h20, 1'b1, 8'h57, 8'd0);
        slotTab[1] = pack(7'h1E, 7'h02, 1'b1, 8'h00, 8'd0);
        slotTab[2] = pack(7'h19, 7'h28, 1'b0, 8'h00, 8'd4);
        slotTab[3] = pack(7'h19, 7'h2C, 1'b0, 8'h00, 8'd2);
        slotTab[4] = pack(7'h1E, 7'h03, 1'b0, 8'h00, 8'd4);
        slotTab[5] = pack(7'h1E, 7'h07, 1'b0, 8'h00, 8'd2);
        for (int i = 2; i <= 5; i++) sh[i] = '0;
        expPcRd  = '0;
        pcExpCmd = '0;

        // reset state
        repeat (3) @(negedge FSM_Clk);
        check("rst_go", I2cGo, 0);
        check("rst_cmd", I2cCmd, 0);
        check("rst_ack", PcAck, 0);
        check("rst_sv", SampleValid, 0);
        check("rst_busy", Busy, 1);
        check("rst_err", Error, 0);
        check("rst_accxy", AccelXY, 0);
        check("rst_magy", MagY, 0);
        check("rst_pcrd", PcReadData, 0);

        // init writes, first one a cycle after reset release
        Reset = 1'b0;
        serveTx(0, 20, $urandom, 1'b1, 1, 0);
        serveTx(1, 20, $urandom, 1'b1, 2, 0);
        @(negedge FSM_Clk);
        check("idle_after_init", Busy, 0);

        // stray completion while idle is ignored
        I2cDone = 1'b1;
        @(negedge FSM_Clk);
        I2cDone = 1'b0;
        check("stray_done_ack", PcAck, 0);
        check("stray_done_busy", Busy, 0);

        // fixed-data round, then a random one
        for (int s = 2; s <= 5; s++)
            serveTx(s, $urandom_range(5, 15), 32'h44332211, 1'b1, (s == 2) ? 0 : 2, 0);
        randRound();

        // PC request during slot 3 slots in before slot 4
        serveTx(2, $urandom_range(5, 15), $urandom, 1'b1, 0, 0);
        serveTx(3, 10, $urandom, 1'b1, 2, 1);
        serveTx(-1, $urandom_range(5, 15), $urandom, 1'b1, 2, 2);
        PcReq = 1'b0;
        serveTx(4, $urandom_range(5, 15), $urandom, 1'b1, 2, 0);
        serveTx(5, $urandom_range(5, 15), $urandom, 1'b1, 2, 0);
        randRound();
        check("no_err_yet", Error, 0);

        // timeout on slot 2: shadow kept, round continues
        serveTx(2, 0, '0, 1'b0, 0, 0);
        check("err_timeout", Error, 1);
        for (int s = 3; s <= 5; s++) serveTx(s, $urandom_range(5, 15), $urandom, 1'b1, 2, 0);

        // reset in the middle of slot 4
        serveTx(2, $urandom_range(5, 15), $urandom, 1'b1, 0, 0);
        serveTx(3, $urandom_range(5, 15), $urandom, 1'b1, 2, 0);
        waitGo(slotTab[4], 2, ok);
        repeat (5) @(negedge FSM_Clk);
        Reset = 1'b1;
        #1;
        check("mid_rst_go", I2cGo, 0);
        check("mid_rst_accxy", AccelXY, 0);
        check("mid_rst_accz", AccelZ, 0);
        check("mid_rst_magxz", MagXZ, 0);
        check("mid_rst_err", Error, 0);
        check("mid_rst_busy", Busy, 1);
        for (int i = 2; i <= 5; i++) sh[i] = '0;
        expPcRd = '0;
        @(negedge FSM_Clk);
        Reset = 1'b0;
        serveTx(0, 20, $urandom, 1'b1, 1, 0);
        serveTx(1, 20, $urandom, 1'b1, 2, 0);

        // slow transactions overrun the poll period
        serveTx(2, 60, $urandom, 1'b1, 0, 0);
        check("no_overrun_yet", Error, 0);
        for (int s = 3; s <= 5; s++) serveTx(s, 60, $urandom, 1'b1, 2, 0);
        check("err_overrun", Error, 1);
        goCnt = 0;
        repeat (100) begin
            @(negedge FSM_Clk);
            if (I2cGo === 1'b1) goCnt++;
        end
        check("no_dup_round", goCnt, 0);
        randRound();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
